// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Run-control sequencer for the 8-bit program counter. Decides
//                each cycle whether the instruction at pc commits and whether
//                a branch is taken. Supports free-run, single-step, a hardware
//                breakpoint and halt. Keeps a saturating retired-instruction
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 pb_clk_debounced,
  input  logic                 rst_general,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 resume_req,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 is_branch,
  input  logic                 branch_cond,
  input  logic                 is_halt_instr,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  output logic                 pc_en,
  output logic [PC_WIDTH-1:0]  take_branch,
  output logic                 commit_en,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    BREAK  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               cur_state;
  logic                 bp_skip;
  logic [CNT_WIDTH-1:0] count;
  logic                 bp_hit;
  logic                 advance;

  // Breakpoint match, suppressed for the one instruction after a resume
  always_comb begin
    bp_hit = bp_enable && (pc == bp_addr) && !bp_skip;
  end

  // Commit decision: zero-latency from registered state and live inputs;
  // reset forces no commit so an aborted RUN/STEP cycle never retires
  always_comb begin
    advance = 1'b0;
    if (!rst_general) begin
      case (cur_state)
        RUN:     advance = !halt_req && !is_halt_instr && !bp_hit;
        STEP:    advance = !is_halt_instr;
        default: advance = 1'b0;
      endcase
    end
  end

  assign pc_en         = advance;
  assign commit_en     = advance;
  assign take_branch   = {{(PC_WIDTH-1){1'b0}}, advance & is_branch & branch_cond};
  assign state         = cur_state;
  assign halted        = (cur_state == HALTED);
  assign retired_count = count;

  // State transitions, breakpoint-skip flag and saturating retire counter
  always_ff @(posedge pb_clk_debounced) begin
    if (rst_general) begin
      cur_state <= IDLE;
      bp_skip   <= 1'b0;
      count     <= '0;
    end else begin
      if (advance && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end

      case (cur_state)
        IDLE: begin
          // run_req outranks step_req
          if (run_req) begin
            cur_state <= RUN;
          end else if (step_req) begin
            cur_state <= STEP;
          end
        end
        RUN: begin
          if (halt_req) begin
            cur_state <= IDLE;
          end else if (is_halt_instr) begin
            cur_state <= HALTED;
          end else if (bp_hit) begin
            cur_state <= BREAK;
          end else begin
            // The skipped instruction has now executed; re-arm the breakpoint
            bp_skip <= 1'b0;
          end
        end
        STEP: begin
          // Breakpoint and halt_req do not apply to a single step
          if (is_halt_instr) begin
            cur_state <= HALTED;
          end else begin
            cur_state <= IDLE;
          end
        end
        BREAK: begin
          // resume_req outranks step_req
          if (resume_req) begin
            bp_skip   <= 1'b1;
            cur_state <= RUN;
          end else if (step_req) begin
            cur_state <= STEP;
          end
        end
        HALTED: begin
          // Only reset leaves HALTED
          cur_state <= HALTED;
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer with an
//                expected-result queue. A second instance with a 4-bit
//                counter shares all inputs to exercise counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_BREAK  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        is_branch = 1'b0, branch_cond = 1'b0, is_halt_instr = 1'b0;
  logic        bp_enable = 1'b0;
  logic [7:0]  bp_addr = 8'h00;

  logic        pc_en, commit_en, halted;
  logic [7:0]  take_branch;
  logic [2:0]  state;
  logic [15:0] retired_count;

  logic        s_pc_en, s_commit_en, s_halted;
  logic [7:0]  s_take_branch;
  logic [2:0]  s_state;
  logic [3:0]  s_retired_count;

  pc_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
    .pb_clk_debounced(clk), .rst_general(rst),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req), .resume_req(resume_req),
    .pc(pc), .is_branch(is_branch), .branch_cond(branch_cond), .is_halt_instr(is_halt_instr),
    .bp_enable(bp_enable), .bp_addr(bp_addr),
    .pc_en(pc_en), .take_branch(take_branch), .commit_en(commit_en),
    .state(state), .halted(halted), .retired_count(retired_count)
  );

  pc_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .pb_clk_debounced(clk), .rst_general(rst),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req), .resume_req(resume_req),
    .pc(pc), .is_branch(is_branch), .branch_cond(branch_cond), .is_halt_instr(is_halt_instr),
    .bp_enable(bp_enable), .bp_addr(bp_addr),
    .pc_en(s_pc_en), .take_branch(s_take_branch), .commit_en(s_commit_en),
    .state(s_state), .halted(s_halted), .retired_count(s_retired_count)
  );

  typedef struct {
    string       tag;
    logic        en;
    logic        tb;
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Queue the expectation for this cycle, compare mid-cycle, then advance
  // one clock and drop the single-cycle request pulses.
  task automatic cyc(input string tag, input logic e_en, input logic e_tb,
                     input logic [2:0] e_st, input logic [15:0] e_cnt);
    exp_t e;
    exp_t got;
    e.tag = tag; e.en = e_en; e.tb = e_tb; e.st = e_st; e.cnt = e_cnt;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk({got.tag, ".pc_en"},       {31'd0, pc_en},        {31'd0, got.en});
    chk({got.tag, ".commit_en"},   {31'd0, commit_en},    {31'd0, got.en});
    chk({got.tag, ".take_branch"}, {24'd0, take_branch},  {31'd0, got.tb});
    chk({got.tag, ".state"},       {29'd0, state},        {29'd0, got.st});
    chk({got.tag, ".halted"},      {31'd0, halted},       {31'd0, (got.st == S_HALTED)});
    chk({got.tag, ".retired"},     {16'd0, retired_count},{16'd0, got.cnt});
    @(posedge clk);
    #1;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset held with run_req, then run
    rst = 1'b1; run_req = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b1; cyc("t1_rst0", 1'b0, 1'b0, S_IDLE, 16'd0);
    run_req = 1'b1; cyc("t1_rst1", 1'b0, 1'b0, S_IDLE, 16'd0);
    rst = 1'b0; run_req = 1'b1; cyc("t1_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    for (int i = 0; i < 5; i++) begin
      pc = 8'(i);
      cyc("t1_run", 1'b1, 1'b0, S_RUN, 16'(i));
    end
    halt_req = 1'b1; cyc("t1_halt", 1'b0, 1'b0, S_RUN, 16'd5);
    cyc("t1_back_idle", 1'b0, 1'b0, S_IDLE, 16'd5);

    // 2. Single step
    do_reset();
    step_req = 1'b1; cyc("t2_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    cyc("t2_step", 1'b1, 1'b0, S_STEP, 16'd0);
    for (int i = 0; i < 10; i++) cyc("t2_quiet", 1'b0, 1'b0, S_IDLE, 16'd1);

    // 3. Breakpoint at 0x04, resume executes it once, re-hit, step through it
    do_reset();
    bp_enable = 1'b1; bp_addr = 8'h04;
    run_req = 1'b1; pc = 8'h00; cyc("t3_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i);
      cyc("t3_run", 1'b1, 1'b0, S_RUN, 16'(i));
    end
    pc = 8'h04; cyc("t3_hit", 1'b0, 1'b0, S_RUN, 16'd4);
    cyc("t3_break_hold", 1'b0, 1'b0, S_BREAK, 16'd4);
    resume_req = 1'b1; cyc("t3_resume", 1'b0, 1'b0, S_BREAK, 16'd4);
    cyc("t3_skip", 1'b1, 1'b0, S_RUN, 16'd4);
    pc = 8'h05; cyc("t3_next", 1'b1, 1'b0, S_RUN, 16'd5);
    pc = 8'h04; cyc("t3_rehit", 1'b0, 1'b0, S_RUN, 16'd6);
    step_req = 1'b1; cyc("t3_break_step", 1'b0, 1'b0, S_BREAK, 16'd6);
    cyc("t3_step_bp", 1'b1, 1'b0, S_STEP, 16'd6);
    cyc("t3_idle_end", 1'b0, 1'b0, S_IDLE, 16'd7);
    bp_enable = 1'b0;

    // 4. Branch gating and reset abort mid-RUN
    do_reset();
    run_req = 1'b1; cyc("t4_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    pc = 8'h10; is_branch = 1'b1; branch_cond = 1'b1;
    cyc("t4_taken", 1'b1, 1'b1, S_RUN, 16'd0);
    branch_cond = 1'b0; cyc("t4_not_taken", 1'b1, 1'b0, S_RUN, 16'd1);
    branch_cond = 1'b1; halt_req = 1'b1; cyc("t4_halt_gate", 1'b0, 1'b0, S_RUN, 16'd2);
    cyc("t4_idle_gate", 1'b0, 1'b0, S_IDLE, 16'd2);
    run_req = 1'b1; cyc("t4_rerun", 1'b0, 1'b0, S_IDLE, 16'd2);
    rst = 1'b1; cyc("t4_rst_abort", 1'b0, 1'b0, S_RUN, 16'd2);
    rst = 1'b0; cyc("t4_after_rst", 1'b0, 1'b0, S_IDLE, 16'd0);
    is_branch = 1'b0; branch_cond = 1'b0;

    // 5. Halt instruction in RUN and in STEP
    do_reset();
    run_req = 1'b1; cyc("t5_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    pc = 8'h06; cyc("t5_run", 1'b1, 1'b0, S_RUN, 16'd0);
    pc = 8'h07; is_halt_instr = 1'b1; cyc("t5_halt_instr", 1'b0, 1'b0, S_RUN, 16'd1);
    run_req = 1'b1; step_req = 1'b1; resume_req = 1'b1;
    cyc("t5_halted", 1'b0, 1'b0, S_HALTED, 16'd1);
    is_halt_instr = 1'b0; run_req = 1'b1; step_req = 1'b1; resume_req = 1'b1;
    cyc("t5_halted2", 1'b0, 1'b0, S_HALTED, 16'd1);
    rst = 1'b1; cyc("t5_rst", 1'b0, 1'b0, S_HALTED, 16'd1);
    rst = 1'b0; step_req = 1'b1; cyc("t5_after", 1'b0, 1'b0, S_IDLE, 16'd0);
    is_halt_instr = 1'b1; cyc("t5_step_halt", 1'b0, 1'b0, S_STEP, 16'd0);
    is_halt_instr = 1'b0; cyc("t5_step_halted", 1'b0, 1'b0, S_HALTED, 16'd0);

    // 6. Saturation (4-bit instance), PC wrap, priority, breakpoint at 0x00
    do_reset();
    run_req = 1'b1; cyc("t6_idle", 1'b0, 1'b0, S_IDLE, 16'd0);
    for (int i = 0; i < 20; i++) begin
      pc = 8'(8'hF0 + i);
      cyc("t6_run", 1'b1, 1'b0, S_RUN, 16'(i));
      if (i == 14) chk("t6_sat_reach", {28'd0, s_retired_count}, 32'd15);
    end
    chk("t6_sat_hold", {28'd0, s_retired_count}, 32'd15);
    pc = 8'h00; bp_enable = 1'b1; bp_addr = 8'h00; halt_req = 1'b1; is_halt_instr = 1'b1;
    cyc("t6_prio", 1'b0, 1'b0, S_RUN, 16'd20);
    is_halt_instr = 1'b0; run_req = 1'b1;
    cyc("t6_prio_idle", 1'b0, 1'b0, S_IDLE, 16'd20);
    cyc("t6_wrap_bp", 1'b0, 1'b0, S_RUN, 16'd20);
    cyc("t6_break", 1'b0, 1'b0, S_BREAK, 16'd20);
    chk("t6_sat_final", {28'd0, s_retired_count}, 32'd15);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
